// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a shared word-addressed memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [1:0]  owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rd,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_adr, mem_wd, owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rd,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_adr, mem_wd, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a shared single-ported memory: sticky ownership with a
// MAX_HOLD burst limit while the other port waits, direct hand-over, registered read data.
module mem_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t      r_state;
    logic [3:0]  r_hold_cnt;
    logic        r_last_served;   // 0 = m0, 1 = m1
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic w_gnt0;
    logic w_gnt1;
    logic w_cur_req;
    logic w_oth_req;
    logic w_at_limit;

    // NOTE: grants are gated by reset combinationally so a reset landing mid-ownership never lets a write through.
    assign w_gnt0     = ~reset & (r_state == OWN0) & bus.m0_req;
    assign w_gnt1     = ~reset & (r_state == OWN1) & bus.m1_req;
    assign w_cur_req  = (r_state == OWN1) ? bus.m1_req : bus.m0_req;
    assign w_oth_req  = (r_state == OWN1) ? bus.m0_req : bus.m1_req;
    assign w_at_limit = (r_hold_cnt == HOLD_LAST);

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m1_rvalid = r_rvalid1;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
    assign bus.owner     = r_state;

    // IDLE presents the m0 side so the memory address is never undriven.
    assign bus.mem_adr = (r_state == OWN1) ? bus.m1_addr  : bus.m0_addr;
    assign bus.mem_wd  = (r_state == OWN1) ? bus.m1_wdata : bus.m0_wdata;
    assign bus.mem_we  = (w_gnt0 & bus.m0_we) | (w_gnt1 & bus.m1_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_hold_cnt    <= '0;
            r_last_served <= 1'b1;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            // NOTE: every state update here is non-blocking so all registers see the pre-edge values.
            r_rvalid0 <= w_gnt0 & ~bus.m0_we;
            r_rvalid1 <= w_gnt1 & ~bus.m1_we;
            if (w_gnt0 & ~bus.m0_we) r_rdata0 <= bus.mem_rd;
            if (w_gnt1 & ~bus.m1_we) r_rdata1 <= bus.mem_rd;

            unique case (r_state)
                IDLE: begin
                    r_hold_cnt <= '0;
                    if (bus.m0_req && (!bus.m1_req || r_last_served)) begin
                        r_state       <= OWN0;
                        r_last_served <= 1'b0;
                    end else if (bus.m1_req) begin
                        r_state       <= OWN1;
                        r_last_served <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!w_cur_req || (w_oth_req && w_at_limit)) begin
                        r_hold_cnt <= '0;
                        if (w_oth_req) begin
                            r_last_served <= (r_state == OWN0);
                            if (r_state == OWN0) r_state <= OWN1;
                            else                 r_state <= OWN0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (!w_at_limit) begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
